// File: rtl/class_search_ctrl_pkg.sv
// hdc_search_pkg: sizes, derived widths and FSM state codes shared by the class search controller.
package hdc_search_pkg;
    localparam int NUM_CLASSES = 8;
    localparam int NUM_FRAMES = 3;
    localparam int FRAME_W = 64;
    localparam int CLASS_ID_W = $clog2(NUM_CLASSES);
    localparam int FRAME_IDX_W = $clog2(NUM_FRAMES);
    localparam int DIST_W = $clog2(NUM_FRAMES * FRAME_W + 1);
    localparam int POP_W = $clog2(FRAME_W + 1);
    localparam logic [1:0] WAIT_Q = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/class_search_ctrl_if.sv
// class_search_ctrl_if: query stream, class ROM address/data and result port of the search controller.
interface class_search_ctrl_if;
    import hdc_search_pkg::*;
    logic q_valid;
    logic q_ready;
    logic [FRAME_W-1:0] q_data;
    logic [CLASS_ID_W-1:0] rom_frame_id;
    logic [FRAME_IDX_W-1:0] rom_frame_index;
    logic [FRAME_W-1:0] rom_vec;
    logic res_valid;
    logic res_ready;
    logic [CLASS_ID_W-1:0] res_class;
    logic [DIST_W-1:0] res_dist;
    logic busy;
    modport master (
        output q_valid, q_data, rom_vec, res_ready,
        input q_ready, rom_frame_id, rom_frame_index, res_valid, res_class, res_dist, busy
    );
    modport slave (
        input q_valid, q_data, rom_vec, res_ready,
        output q_ready, rom_frame_id, rom_frame_index, res_valid, res_class, res_dist, busy
    );
endinterface

// File: rtl/class_search_ctrl_popcount_frame.sv
// popcount_frame: combinational population count of one W-bit frame.
module popcount_frame #(
    parameter int W = 64
) (
    input  logic [W-1:0]         v,
    output logic [$clog2(W+1)-1:0] cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) cnt = cnt + $bits(cnt)'(v[i]);
    end
endmodule

// File: rtl/class_search_ctrl.sv
// class_search_ctrl: per query frame, sweeps all class ROM vectors accumulating Hamming distance; returns argmin.
module class_search_ctrl
    import hdc_search_pkg::*;
(
    input logic clk,
    input logic rst,
    class_search_ctrl_if.slave bus
);
    logic [1:0] state;
    logic [FRAME_IDX_W-1:0] frm;
    logic [CLASS_ID_W-1:0] cls;
    logic [FRAME_W-1:0] q_reg;
    logic [DIST_W-1:0] acc [NUM_CLASSES];
    logic [CLASS_ID_W-1:0] best_cls, res_class;
    logic [DIST_W-1:0] best_dist, res_dist, new_sum;
    logic [POP_W-1:0] d;
    logic last_cls, last_frm, upd;

    popcount_frame #(.W(FRAME_W)) u_pop (.v(q_reg ^ bus.rom_vec), .cnt(d));

    assign last_cls = cls == CLASS_ID_W'(NUM_CLASSES - 1);
    assign last_frm = frm == FRAME_IDX_W'(NUM_FRAMES - 1);
    assign new_sum = (frm == '0 ? '0 : acc[cls]) + DIST_W'(d);
    // strict compare keeps the lowest class id on ties
    assign upd = cls == '0 || new_sum < best_dist;

    assign bus.q_ready = state == WAIT_Q;
    assign bus.busy = state != WAIT_Q;
    assign bus.res_valid = state == DONE;
    assign bus.res_class = res_class;
    assign bus.res_dist = res_dist;
    assign bus.rom_frame_id = cls;
    assign bus.rom_frame_index = frm;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_Q;
            frm <= '0;
            cls <= '0;
            q_reg <= '0;
            best_cls <= '0;
            best_dist <= '0;
            res_class <= '0;
            res_dist <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) acc[i] <= '0;
        end else begin
            case (state)
                WAIT_Q: if (bus.q_valid) begin
                    q_reg <= bus.q_data;
                    cls <= '0;
                    state <= SCAN;
                end
                SCAN: begin
                    acc[cls] <= new_sum;
                    if (last_frm && upd) begin
                        best_cls <= cls;
                        best_dist <= new_sum;
                    end
                    if (!last_cls) cls <= cls + 1'b1;
                    else if (last_frm) begin
                        res_class <= upd ? cls : best_cls;
                        res_dist <= upd ? new_sum : best_dist;
                        state <= DONE;
                    end else begin
                        frm <= frm + 1'b1;
                        state <= WAIT_Q;
                    end
                end
                DONE: if (bus.res_ready) begin
                    frm <= '0;
                    state <= WAIT_Q;
                end
                default: state <= WAIT_Q;
            endcase
        end
    end
endmodule

// File: tb/tb_class_search_ctrl.sv
// tb_class_search_ctrl: directed and random queries checked against a brute-force nearest-class model.
module tb_class_search_ctrl;
    import hdc_search_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    class_search_ctrl_if bus();
    class_search_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    logic [FRAME_W-1:0] rom [NUM_CLASSES][NUM_FRAMES];
    logic [FRAME_W-1:0] qf [NUM_FRAMES];
    assign bus.rom_vec = (int'(bus.rom_frame_index) < NUM_FRAMES) ? rom[bus.rom_frame_id][bus.rom_frame_index] : '0;

    int total = 0, bad = 0, cyc = 0, idx3 = 0;
    int acc_cyc [NUM_FRAMES];
    int res_cyc, exp_cls, exp_dist;
    logic [CLASS_ID_W-1:0] got_cls;
    logic [DIST_W-1:0] got_dist;
    bit mon = 0;
    logic [4:0] addr_q [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.rom_frame_index == 2'd3) idx3++;
        if (mon && bus.busy && !bus.res_valid) addr_q.push_back({3'(bus.rom_frame_index), bus.rom_frame_id});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // nearest class by summed frame Hamming distance, first minimum wins
    task automatic model();
        for (int c = 0; c < NUM_CLASSES; c++) begin
            int sum = 0;
            for (int f = 0; f < NUM_FRAMES; f++) sum += $countones(rom[c][f] ^ qf[f]);
            if (c == 0 || sum < exp_dist) begin
                exp_dist = sum;
                exp_cls = c;
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.q_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.q_ready) chk("q_ready_timeout", 0, 1);
    endtask

    task automatic do_query(input int gap_max, input int hold, input bit rr_rand);
        int n = 0;
        for (int f = 0; f < NUM_FRAMES; f++) begin
            if (f > 0) @(negedge clk);
            bus.res_ready = rr_rand ? 1'($urandom) : 1'b0;
            if (gap_max > 0) begin
                bus.q_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
            end
            bus.q_valid = 1'b1;
            bus.q_data = qf[f];
            wait_ready();
            acc_cyc[f] = cyc;
            @(posedge clk);
            #1;
        end
        bus.res_ready = 1'b0;
        @(negedge clk);
        while (!bus.res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.q_valid = 1'b0;
        if (!bus.res_valid) chk("res_valid_timeout", 0, 1);
        res_cyc = cyc - acc_cyc[0];
        got_cls = bus.res_class;
        got_dist = bus.res_dist;
        repeat (hold) begin
            @(negedge clk);
            chk("bp_res_valid", bus.res_valid, 1);
            chk("bp_res_class", bus.res_class, got_cls);
            chk("bp_res_dist", bus.res_dist, got_dist);
            chk("bp_q_ready", bus.q_ready, 0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("q_ready_after_res", bus.q_ready, 1);
        chk("res_valid_after_res", bus.res_valid, 0);
        bus.res_ready = 1'b0;
    endtask

    task automatic fill_rom();
        for (int c = 0; c < NUM_CLASSES; c++)
            for (int f = 0; f < NUM_FRAMES; f++) rom[c][f] = {$urandom, $urandom};
    endtask

    initial begin
        bus.q_valid = 1'b0;
        bus.q_data = '0;
        bus.res_ready = 1'b0;
        fill_rom();
        repeat (3) @(negedge clk);
        chk("rst_q_ready", bus.q_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_class", bus.res_class, 0);
        chk("rst_res_dist", bus.res_dist, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rom_id", bus.rom_frame_id, 0);
        chk("rst_rom_idx", bus.rom_frame_index, 0);
        rst = 1'b0;
        @(negedge clk);

        // exact match with q_valid held, timing, address sweep and backpressure
        for (int f = 0; f < NUM_FRAMES; f++) qf[f] = rom[3][f];
        addr_q.delete();
        mon = 1;
        do_query(0, 5, 0);
        mon = 0;
        chk("exact_t1", acc_cyc[1] - acc_cyc[0], 9);
        chk("exact_t2", acc_cyc[2] - acc_cyc[0], 18);
        chk("exact_res_t", res_cyc, 27);
        chk("exact_cls", got_cls, 3);
        chk("exact_dist", got_dist, 0);
        chk("sweep_len", addr_q.size(), NUM_FRAMES * NUM_CLASSES);
        for (int i = 0; i < addr_q.size() && i < NUM_FRAMES * NUM_CLASSES; i++)
            chk("sweep_addr", addr_q[i], {3'(i / NUM_CLASSES), 3'(i % NUM_CLASSES)});

        // single-bit error in frame 1
        for (int f = 0; f < NUM_FRAMES; f++) qf[f] = rom[5][f];
        qf[1][0] = ~qf[1][0];
        do_query(0, 0, 0);
        chk("flip_cls", got_cls, 5);
        chk("flip_dist", got_dist, 1);

        // all classes equally distant
        for (int c = 0; c < NUM_CLASSES; c++)
            for (int f = 0; f < NUM_FRAMES; f++) rom[c][f] = '0;
        for (int f = 0; f < NUM_FRAMES; f++) qf[f] = '1;
        do_query(0, 1, 0);
        chk("tie_cls", got_cls, 0);
        chk("tie_dist", got_dist, 192);
        fill_rom();

        // reset while scanning frame 1 at class 4
        bus.q_valid = 1'b1;
        bus.q_data = rom[6][0];
        wait_ready();
        @(posedge clk);
        #1;
        bus.q_data = rom[6][1];
        @(negedge clk);
        wait_ready();
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mid_rom_id", bus.rom_frame_id, 4);
        chk("mid_rom_idx", bus.rom_frame_index, 1);
        rst = 1'b1;
        bus.q_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_q_ready", bus.q_ready, 1);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_idx", bus.rom_frame_index, 0);
        rst = 1'b0;
        @(negedge clk);
        for (int f = 0; f < NUM_FRAMES; f++) qf[f] = rom[0][f];
        do_query(0, 0, 0);
        chk("post_rst_cls", got_cls, 0);
        chk("post_rst_dist", got_dist, 0);

        // random queries with gaps, stray res_ready and occasional duplicate classes
        for (int it = 0; it < 25; it++) begin
            int k;
            fill_rom();
            k = $urandom_range(0, NUM_CLASSES - 1);
            if ($urandom_range(0, 2) == 0) begin
                int j = $urandom_range(0, NUM_CLASSES - 1);
                for (int f = 0; f < NUM_FRAMES; f++) rom[j][f] = rom[k][f];
            end
            for (int f = 0; f < NUM_FRAMES; f++)
                qf[f] = $urandom_range(0, 3) == 0 ? {$urandom, $urandom}
                      : rom[k][f] ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
            model();
            do_query(2, $urandom_range(0, 3), 1);
            chk("rnd_cls", got_cls, exp_cls);
            chk("rnd_dist", got_dist, exp_dist);
        end

        chk("idx_never_3", idx3, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
